// File: rtl/server_traffic_gen_v2_if.sv
// AXI-Stream TX/RX bundle for server_traffic_gen_v2.
// master: drives tx_axis_* and rx_axis_tready; slave: the peer side.
interface server_traffic_gen_v2_if;
  logic        tx_axis_tvalid;
  logic [63:0] tx_axis_tdata;
  logic        tx_axis_tlast;
  logic [7:0]  tx_axis_tkeep;
  logic        tx_axis_tuser;
  logic        tx_axis_tready;
  logic        rx_axis_tvalid;
  logic [63:0] rx_axis_tdata;
  logic        rx_axis_tlast;
  logic [7:0]  rx_axis_tkeep;
  logic        rx_axis_tuser;
  logic        rx_axis_tready;

  modport master (
    output tx_axis_tvalid, tx_axis_tdata, tx_axis_tlast,
    output tx_axis_tkeep, tx_axis_tuser,
    input  tx_axis_tready,
    input  rx_axis_tvalid, rx_axis_tdata, rx_axis_tlast,
    input  rx_axis_tkeep, rx_axis_tuser,
    output rx_axis_tready
  );

  modport slave (
    input  tx_axis_tvalid, tx_axis_tdata, tx_axis_tlast,
    input  tx_axis_tkeep, tx_axis_tuser,
    output tx_axis_tready,
    output rx_axis_tvalid, rx_axis_tdata, rx_axis_tlast,
    output rx_axis_tkeep, rx_axis_tuser,
    input  rx_axis_tready
  );
endinterface

// File: rtl/server_traffic_gen_v2.sv
// Server traffic generator (random-destination frames on AXIS TX) plus
// a 2-stage MAC lookup returning output port and seek class.
// Ports: i_clk, i_rst_n (sync, active low), link/timestamp/connect-ToR,
// sim start/stop, lookup request/result, o_tx_pkt_cnt, axis (master).
// Option: define SRV_GEN_SEQ_NUM_EN to put a frame sequence number in
// beat1[15:0]; undefined leaves those bits zero.
module server_traffic_gen_v2 #(
  parameter int          P_UPLINK_TRUE = 0,
  parameter int          P_TOR_NUM     = 8,
  parameter int          P_SRV_NUM     = 2,
  parameter int          P_MY_TOR_ID   = 0,
  parameter int          P_MY_SRV_ID   = 1,
  parameter logic [31:0] P_MAC_HEAD    = 32'h8DBC5C4A,
  parameter logic [15:0] P_SEED        = 16'hA5A5,
  parameter int          P_PKT_LEN     = 128,
  parameter int          P_GAP_CYCLE   = 8,
  parameter int          P_SKIP_LOCAL  = 1,
  parameter int          P_ID_W        = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_stat_rx_status,
  input  logic [63:0]                  i_time_stamp,
  input  logic [$clog2(P_TOR_NUM)-1:0] i_cur_connect_tor,
  input  logic                         i_sim_start,
  input  logic                         i_sim_stop,
  input  logic [47:0]                  i_check_mac,
  input  logic [P_ID_W-1:0]            i_check_id,
  input  logic                         i_check_valid,
  output logic [7:0]                   o_outport,
  output logic [1:0]                   o_seek_flag,
  output logic [P_ID_W-1:0]            o_check_id,
  output logic                         o_result_valid,
  output logic [31:0]                  o_tx_pkt_cnt,
  server_traffic_gen_v2_if.master      axis
);
  localparam int BEAT_W = $clog2(P_PKT_LEN);
  localparam int GAP_W  = $clog2(P_GAP_CYCLE + 1);
  localparam bit UPL    = (P_UPLINK_TRUE != 0);
  localparam logic [15:0] SEED =
    (P_SEED == 16'h0) ? 16'hACE1 : P_SEED;
  localparam logic [7:0] TOR_MSK = 8'(P_TOR_NUM - 1);
  localparam logic [7:0] SRV_MSK = 8'(P_SRV_NUM - 1);
  localparam logic [7:0] MY_TOR  = 8'(P_MY_TOR_ID);
  localparam logic [47:0] OWN_MAC =
    {P_MAC_HEAD, MY_TOR, 8'(P_MY_SRV_ID)};
  localparam logic [BEAT_W-1:0] LAST_B = BEAT_W'(P_PKT_LEN - 1);
  localparam logic [BEAT_W-1:0] PEN_B  = BEAT_W'(P_PKT_LEN - 2);
  localparam logic [GAP_W-1:0]  LAST_G = GAP_W'(P_GAP_CYCLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RAND0, S_RAND1, S_DATA, S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic              en_q, en_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [63:0]       tdata_q, tdata_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              acc, done;
  logic [15:0]       seq_val;
  logic [7:0]        tor_raw, dst_tor, dst_srv;
  logic              unused_rx;

  assign acc  = (state_q == S_DATA) && tvalid_q
             && axis.tx_axis_tready;
  assign done = acc && (beat_q == LAST_B);

`ifdef SRV_GEN_SEQ_NUM_EN
  logic [15:0] seq_q, seq_d;
  always_comb begin
    seq_d = seq_q;
    if (done) seq_d = seq_q + 16'd1;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) seq_q <= '0;
    else          seq_q <= seq_d;
  end
  assign seq_val = seq_q;
`else
  assign seq_val = 16'h0000;
`endif

  // Destination pick; masks keep the index fields zero-width safe.
  always_comb begin
    tor_raw = lfsr_q[7:0] & TOR_MSK;
    dst_tor = tor_raw;
    if (P_SKIP_LOCAL != 0 && tor_raw == MY_TOR)
      dst_tor = (tor_raw + 8'd1) & TOR_MSK;
    dst_srv = (lfsr_q[15:8] & SRV_MSK) + 8'd1;
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    lfsr_d   = lfsr_q;
    beat_d   = beat_q;
    gap_d    = gap_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    cnt_d    = cnt_q;
    if (i_sim_stop)       en_d = 1'b0;
    else if (i_sim_start) en_d = 1'b1;
    unique case (state_q)
      S_IDLE:
        if (en_q && i_stat_rx_status && !UPL)
          state_d = S_RAND0;
      S_RAND0: begin
        lfsr_d = {lfsr_q[14:0],
                  lfsr_q[15] ^ lfsr_q[13]
                  ^ lfsr_q[12] ^ lfsr_q[10]};
        state_d = S_RAND1;
      end
      S_RAND1: begin
        tvalid_d = 1'b1;
        tlast_d  = 1'b0;
        beat_d   = '0;
        tdata_d  = {P_MAC_HEAD, dst_tor, dst_srv,
                    OWN_MAC[47:32]};
        state_d  = S_DATA;
      end
      S_DATA:
        if (done) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          cnt_d    = cnt_q + 32'd1;
          gap_d    = '0;
          state_d  = S_GAP;
        end else if (acc) begin
          beat_d  = beat_q + 1'b1;
          tlast_d = (beat_q == PEN_B);
          if (beat_q == '0)
            tdata_d = {OWN_MAC[31:0], 16'h0800, seq_val};
          else
            tdata_d = i_time_stamp;
        end
      S_GAP:
        if (gap_q == LAST_G) state_d = S_IDLE;
        else                 gap_d = gap_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      lfsr_q   <= SEED;
      beat_q   <= '0;
      gap_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      lfsr_q   <= lfsr_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign axis.tx_axis_tvalid = tvalid_q;
  assign axis.tx_axis_tdata  = tdata_q;
  assign axis.tx_axis_tlast  = tlast_q;
  assign axis.tx_axis_tkeep  = tvalid_q ? 8'hFF : 8'h00;
  assign axis.tx_axis_tuser  = 1'b0;
  assign axis.rx_axis_tready = 1'b1;
  assign o_tx_pkt_cnt        = cnt_q;

  assign unused_rx = ^{axis.rx_axis_tvalid, axis.rx_axis_tdata,
                       axis.rx_axis_tlast, axis.rx_axis_tkeep,
                       axis.rx_axis_tuser};

  // Lookup: stage 1 captures the request, stage 2 the result.
  logic [47:0]       mac1_q;
  logic [P_ID_W-1:0] id1_q;
  logic              vld1_q;
  logic [7:0]        port_q, port_d;
  logic [1:0]        flag_q, flag_d;
  logic [P_ID_W-1:0] rid_q, rid_d;
  logic              rv_q;
  logic              l_mine, l_srv0, l_conn;

  always_comb begin
    l_mine = (mac1_q[47:16] == P_MAC_HEAD)
          && (mac1_q[15:8] == MY_TOR);
    l_srv0 = (mac1_q[7:0] == 8'd0);
    l_conn = (mac1_q[15:8] == 8'(i_cur_connect_tor));
    port_d = port_q;
    flag_d = flag_q;
    rid_d  = rid_q;
    if (vld1_q) begin
      rid_d = id1_q;
      unique case (1'b1)
        l_mine && !l_srv0: begin
          flag_d = 2'd1;
          port_d = mac1_q[7:0];
        end
        l_mine && l_srv0: begin
          flag_d = UPL ? 2'd3 : 2'd0;
          port_d = 8'd0;
        end
        default: begin
          flag_d = (UPL && l_conn) ? 2'd2 : 2'd0;
          port_d = mac1_q[15:8];
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mac1_q <= '0;
      id1_q  <= '0;
      vld1_q <= 1'b0;
      port_q <= '0;
      flag_q <= '0;
      rid_q  <= '0;
      rv_q   <= 1'b0;
    end else begin
      mac1_q <= i_check_mac;
      id1_q  <= i_check_id;
      vld1_q <= i_check_valid;
      port_q <= port_d;
      flag_q <= flag_d;
      rid_q  <= rid_d;
      rv_q   <= vld1_q;
    end
  end

  assign o_outport      = port_q;
  assign o_seek_flag    = flag_q;
  assign o_check_id     = rid_q;
  assign o_result_valid = rv_q;
endmodule

// File: tb/tb_server_traffic_gen_v2.sv
// Directed bench for server_traffic_gen_v2: downlink generator and
// lookup instance plus an uplink lookup-only instance.
module tb_server_traffic_gen_v2;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        link;
  logic [63:0] ts;
  logic [2:0]  cur_tor;
  logic        start, stop;
  logic [47:0] ck_mac;
  logic [3:0]  ck_id;
  logic        ck_vld;
  logic [7:0]  dl_port, ul_port;
  logic [1:0]  dl_flag, ul_flag;
  logic [3:0]  dl_id, ul_id;
  logic        dl_rv, ul_rv;
  logic [31:0] dl_cnt, ul_cnt;
  int          n_tot = 0;
  int          n_pass = 0;
  bit          ul_seen = 1'b0;

  localparam logic [31:0] HD = 32'h8DBC5C4A;
  localparam logic [63:0] F0 = 64'h8DBC5C4A0302_8DBC;
  localparam logic [63:0] F1 = 64'h8DBC5C4A0601_8DBC;
  localparam logic [63:0] F2 = 64'h8DBC5C4A0502_8DBC;
  localparam logic [63:0] B1 = 64'h5C4A0001_0800_0000;

  server_traffic_gen_v2_if dl_if ();
  server_traffic_gen_v2_if ul_if ();

  server_traffic_gen_v2 dut_dl (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_stat_rx_status(link), .i_time_stamp(ts),
    .i_cur_connect_tor(cur_tor),
    .i_sim_start(start), .i_sim_stop(stop),
    .i_check_mac(ck_mac), .i_check_id(ck_id),
    .i_check_valid(ck_vld),
    .o_outport(dl_port), .o_seek_flag(dl_flag),
    .o_check_id(dl_id), .o_result_valid(dl_rv),
    .o_tx_pkt_cnt(dl_cnt), .axis(dl_if)
  );

  server_traffic_gen_v2 #(.P_UPLINK_TRUE(1)) dut_ul (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_stat_rx_status(link), .i_time_stamp(ts),
    .i_cur_connect_tor(cur_tor),
    .i_sim_start(start), .i_sim_stop(stop),
    .i_check_mac(ck_mac), .i_check_id(ck_id),
    .i_check_valid(ck_vld),
    .o_outport(ul_port), .o_seek_flag(ul_flag),
    .o_check_id(ul_id), .o_result_valid(ul_rv),
    .o_tx_pkt_cnt(ul_cnt), .axis(ul_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ul_if.tx_axis_tvalid === 1'b1) ul_seen = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic lk(input logic [47:0] m, input logic [3:0] id);
    ck_mac = m;
    ck_id  = id;
    ck_vld = 1'b1;
  endtask

  task automatic res(input string tag, input bit up,
                     input logic [1:0] f, input logic [7:0] p,
                     input logic [3:0] id);
    chk({tag, "_rv"}, up ? ul_rv : dl_rv, 1);
    chk({tag, "_flag"}, up ? ul_flag : dl_flag, f);
    chk({tag, "_port"}, up ? ul_port : dl_port, p);
    chk({tag, "_id"}, up ? ul_id : dl_id, id);
  endtask

  // Runs one downlink frame from the current negedge. Timestamp moves
  // every cycle; each beat >= 2 must carry the value present when the
  // previous beat was accepted.
  task automatic run_frame(input int stall_at, input int stop_at,
                           input logic [63:0] exp_d0,
                           input int exp_cnt, input bit meas_gap);
    int guard, nb, nlast, lastpos, drops, derr, gap;
    logic [63:0] held, d1, prev_ts;
    logic hl;
    bit done, stalled;
    guard = 0; nb = 0; nlast = 0; lastpos = -1;
    drops = 0; derr = 0; done = 0; stalled = 0;
    d1 = '0; prev_ts = '0;
    while (!dl_if.tx_axis_tvalid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("frame_start", dl_if.tx_axis_tvalid, 1);
    if (!dl_if.tx_axis_tvalid) return;
    chk("beat0", dl_if.tx_axis_tdata, exp_d0);
    chk("tkeep", dl_if.tx_axis_tkeep, 8'hFF);
    chk("tuser", dl_if.tx_axis_tuser, 0);
    while (!done && guard < 2000) begin
      ts = ts + 64'h1_0000_0001;
      if (!stalled && nb == stall_at) begin
        stalled = 1;
        held = dl_if.tx_axis_tdata;
        hl = dl_if.tx_axis_tlast;
        dl_if.tx_axis_tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          ts = ts + 64'h1_0000_0001;
          chk("stall_data", dl_if.tx_axis_tdata, held);
          chk("stall_vld", dl_if.tx_axis_tvalid, 1);
          chk("stall_last", dl_if.tx_axis_tlast, hl);
        end
        dl_if.tx_axis_tready = 1'b1;
      end
      stop = (nb == stop_at);
      if (!dl_if.tx_axis_tvalid) drops++;
      if (nb == 1) d1 = dl_if.tx_axis_tdata;
      if (nb >= 2 && dl_if.tx_axis_tdata !== prev_ts) derr++;
      if (dl_if.tx_axis_tlast) begin
        nlast++;
        lastpos = nb;
      end
      if (dl_if.tx_axis_tvalid && dl_if.tx_axis_tready) begin
        prev_ts = ts;
        if (dl_if.tx_axis_tlast) done = 1;
        nb++;
      end
      @(negedge clk);
      guard++;
    end
    stop = 1'b0;
    chk("beats", nb, 128);
    chk("tlast_pos", lastpos, 127);
    chk("tlast_cnt", nlast, 1);
    chk("vld_drop", drops, 0);
    chk("beat1", d1, B1);
    chk("ts_beats", derr, 0);
    chk("pkt_cnt", dl_cnt, exp_cnt);
    chk("post_vld", dl_if.tx_axis_tvalid, 0);
    if (meas_gap) begin
      gap = 0;
      while (!dl_if.tx_axis_tvalid && gap < 100) begin
        @(negedge clk);
        gap++;
      end
      chk("gap", gap, 11);
    end
  endtask

  initial begin
    int g;
    bit seen;
    rst_n = 1'b0; link = 1'b1; ts = 64'h1000_0000_0000_0000;
    cur_tor = 3'd3; start = 1'b0; stop = 1'b0;
    ck_mac = '0; ck_id = '0; ck_vld = 1'b0;
    dl_if.tx_axis_tready = 1'b1; ul_if.tx_axis_tready = 1'b1;
    dl_if.rx_axis_tvalid = 1'b0; ul_if.rx_axis_tvalid = 1'b0;
    dl_if.rx_axis_tdata = '0;    ul_if.rx_axis_tdata = '0;
    dl_if.rx_axis_tlast = 1'b0;  ul_if.rx_axis_tlast = 1'b0;
    dl_if.rx_axis_tkeep = '0;    ul_if.rx_axis_tkeep = '0;
    dl_if.rx_axis_tuser = 1'b0;  ul_if.rx_axis_tuser = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vld", dl_if.tx_axis_tvalid, 0);
    chk("rst_data", dl_if.tx_axis_tdata, 0);
    chk("rst_last", dl_if.tx_axis_tlast, 0);
    chk("rst_keep", dl_if.tx_axis_tkeep, 0);
    chk("rst_cnt", dl_cnt, 0);
    chk("rst_rv", dl_rv, 0);
    chk("rst_flag", dl_flag, 0);
    chk("rst_port", dl_port, 0);
    chk("rst_rxrdy", dl_if.rx_axis_tready, 1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_no_start", dl_if.tx_axis_tvalid, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_frame(-1, -1, F0, 1, 1);
    run_frame(10, -1, F1, 2, 1);
    run_frame(-1, 50, F2, 3, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dl_if.tx_axis_tvalid) seen = 1;
    end
    chk("no_frame_after_stop", seen, 0);
    chk("cnt_after_stop", dl_cnt, 3);

    lk({HD, 8'h00, 8'h02}, 4'd1);
    @(negedge clk);
    chk("dl_rv_lat1", dl_rv, 0);
    lk({HD, 8'h05, 8'h01}, 4'd2);
    @(negedge clk);
    res("dl_xbar", 0, 2'd1, 8'd2, 4'd1);
    lk({HD, 8'h00, 8'h00}, 4'd3);
    @(negedge clk);
    res("dl_ddr", 0, 2'd0, 8'd5, 4'd2);
    lk({32'h12345678, 8'h06, 8'h02}, 4'd4);
    @(negedge clk);
    res("dl_ctl", 0, 2'd0, 8'd0, 4'd3);
    ck_vld = 1'b0;
    @(negedge clk);
    res("dl_nohead", 0, 2'd0, 8'd6, 4'd4);
    @(negedge clk);
    chk("dl_rv_off", dl_rv, 0);
    chk("dl_hold_port", dl_port, 6);
    chk("dl_hold_id", dl_id, 4);

    lk({HD, 8'h03, 8'h01}, 4'd5);
    @(negedge clk);
    lk({HD, 8'h04, 8'h01}, 4'd6);
    @(negedge clk);
    res("ul_twohop", 1, 2'd2, 8'd3, 4'd5);
    lk({HD, 8'h00, 8'h00}, 4'd7);
    @(negedge clk);
    res("ul_relay", 1, 2'd0, 8'd4, 4'd6);
    lk({HD, 8'h00, 8'h02}, 4'd8);
    @(negedge clk);
    res("ul_vlb", 1, 2'd3, 8'd0, 4'd7);
    ck_vld = 1'b0;
    @(negedge clk);
    res("ul_xbar", 1, 2'd1, 8'd2, 4'd8);
    @(negedge clk);
    chk("ul_rv_off", ul_rv, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!dl_if.tx_axis_tvalid && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("rst_frame_start", dl_if.tx_axis_tvalid, 1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_vld", dl_if.tx_axis_tvalid, 0);
    chk("rst_mid_last", dl_if.tx_axis_tlast, 0);
    chk("rst_mid_cnt", dl_cnt, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (dl_if.tx_axis_tvalid) seen = 1;
    end
    chk("en_cleared", seen, 0);

    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (dl_if.tx_axis_tvalid) seen = 1;
    end
    chk("stop_wins", seen, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_frame(-1, -1, F0, 1, 0);
    chk("ul_never_tx", ul_seen, 0);
    chk("ul_cnt", ul_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/server_traffic_gen_v2.md
Name: server_traffic_gen_v2

Overview:
Parametrised successor to the per-port server traffic source and forwarding-lookup block. Generates random-destination Ethernet test frames for any ToR/server count over a backpressure-aware AXI-Stream TX, and runs a fully pipelined MAC lookup that returns the output port and seek class. Sits between the ToR port MAC and the crossbar/DDR queue logic. Uplink mode (lookup only) and downlink mode (generator plus lookup) are selected by parameter.

Parameters:
P_UPLINK_TRUE, 0, 1 = uplink port: generator disabled, uplink seek rules
P_TOR_NUM, 8, ToR count; power of two, 2..256
P_SRV_NUM, 2, servers per ToR; power of two, 1..128
P_MY_TOR_ID, 0, this ToR's index
P_MY_SRV_ID, 1, this port's server index (1..P_SRV_NUM)
P_MAC_HEAD, 32'h8DBC5C4A, MAC bits [47:16]
P_SEED, 16'hA5A5, LFSR seed; 0 is replaced by 16'hACE1
P_PKT_LEN, 128, beats per frame, >=3
P_GAP_CYCLE, 8, idle cycles between frames, >=1
P_SKIP_LOCAL, 1, 1 = never target own ToR
P_ID_W, 4, lookup tag width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_stat_rx_status  in  1  link up; no new frame starts while low
i_time_stamp  in  64  payload source
i_cur_connect_tor  in  TOR_W=clog2(P_TOR_NUM)  ToR currently reachable via the optical slot
i_sim_start  in  1  pulse: enable generation (sticky)
i_sim_stop  in  1  pulse: clear enable; the current frame completes
i_check_mac  in  48  lookup destination MAC
i_check_id  in  P_ID_W  lookup tag
i_check_valid  in  1  lookup request; always accepted
o_outport  out  8  result port
o_seek_flag  out  2  result class
o_check_id  out  P_ID_W  echoed tag
o_result_valid  out  1  one-cycle result strobe
o_tx_pkt_cnt  out  32  completed frames, wraps
tx_axis_tvalid/tdata[63:0]/tlast/tkeep[7:0]/tuser  out  AXIS TX
tx_axis_tready  in  1  TX backpressure
rx_axis_*  in  standard  sink; rx_axis_tready tied 1

Behaviour:
- Reset: all outputs 0, rx_axis_tready 1, FSM IDLE, LFSR = seed, enable latch 0.
- Enable latch: set by i_sim_start, cleared by i_sim_stop. When both pulse in the same cycle, stop wins.
- FSM IDLE: go to RAND when enable && i_stat_rx_status && !P_UPLINK_TRUE.
- RAND, 2 cycles:
  - Cycle 0: LFSR shifts left. Feedback = b15^b13^b12^b10.
  - Cycle 1: dest_tor = lfsr[TOR_W-1:0]. If P_SKIP_LOCAL and dest_tor == P_MY_TOR_ID, use dest_tor+1 mod P_TOR_NUM. dest_srv = lfsr[8 +: SRV_W] + 1.
  - dest MAC = {P_MAC_HEAD, 8'(dest_tor), 8'(dest_srv)}. Own MAC uses the same format.
- DATA, P_PKT_LEN accepted beats:
  - beat0 = {dest_mac, own_mac[47:32]}
  - beat1 = {own_mac[31:0], 16'h0800, 16'h0000}
  - remaining beats = i_time_stamp, sampled when the beat is loaded
  - tkeep 8'hFF, tuser 0, tlast on the final beat only.
  - Beat counter advances only on tvalid && tready. While tready is low, tdata, tlast and tvalid hold. tvalid never drops mid-frame.
  - Final beat accepted: o_tx_pkt_cnt +1, go to GAP.
- GAP: P_GAP_CYCLE cycles with tvalid 0, then IDLE. Back-to-back frames therefore cost GAP + 1 (IDLE) + 2 (RAND) cycles.
- Stop or link-down mid-frame: the frame completes; the FSM then idles.
- Lookup pipeline, latency 2, throughput 1/cycle:
  - Stage 1 registers mac, id and valid.
  - Stage 2 registers the result; o_result_valid = stage-1 valid delayed.
  - o_seek_flag, o_outport and o_check_id hold their last values when no result is valid.
- Lookup decode. head = mac[47:16]==P_MAC_HEAD; tor = mac[15:8]; srv = mac[7:0].
  - head && tor==MY && srv!=0: flag 1 (crossbar), outport = srv.
  - head && tor==MY && srv==0: uplink → flag 3 (VLB control); downlink → flag 0. outport 0.
  - Otherwise, downlink: flag 0 (local DDR queue), outport = tor.
  - Otherwise, uplink: flag 2 (two-hop FIFO) if tor == i_cur_connect_tor at stage 2, else flag 0 (relay DDR). outport = tor.
  - Head mismatch is treated as non-local using the same rules.

Optional Feature:
SRV_GEN_SEQ_NUM_EN:
- Defined: beat1[15:0] carries a 16-bit per-port frame sequence number. It starts at 0 after reset and increments on each completed frame, wrapping at 16'hFFFF→0.
- Undefined: beat1[15:0] = 16'h0000 and no sequence counter is built.

Test Plan:
- Reset, then a single i_sim_start with tready=1, P_SEED=16'hA5A5, default params → first beat0[63:16] has P_MAC_HEAD, tor ≠ 0, srv ∈ {1,2}; frame of exactly 128 beats; tlast on beat 127; o_tx_pkt_cnt=1.
- Drop tready for 5 cycles on beat 10 → tdata/tvalid stable for those cycles; frame still 128 accepted beats; next frame starts 8+3 cycles after the last accept.
- Pulse i_sim_stop at beat 50 → frame completes; no further tvalid; o_tx_pkt_cnt increments by 1 only.
- Downlink, lookups on consecutive cycles: MAC {HEAD,00,02} → flag1/port2; {HEAD,05,01} → flag0/port5; {HEAD,00,00} → flag0/port0. Each result 2 cycles after its request, ids echoed in order.
- P_UPLINK_TRUE=1, i_cur_connect_tor=3: {HEAD,03,01} → flag2/port3; {HEAD,04,01} → flag0/port4; {HEAD,00,00} → flag3/port0; no tvalid ever.
- Assert i_rst_n low mid-frame → next clock: tvalid 0, FSM IDLE, o_tx_pkt_cnt 0, enable latch cleared.
